// File: rtl/datapath_sequencer.sv
// Instruction sequencer: fetch/decode/execute control for a simple ARM-like datapath.
// Latency: Moore outputs follow the registered state; IRLd/MDRLd/undef/mem_abort resolve in-cycle.
// Backpressure: F2/LDW/STW hold until moc=1, or abort to F0 after MOC_TIMEOUT stalled cycles.
module datapath_sequencer #(
    parameter int unsigned MOC_TIMEOUT = 15,
    parameter logic [4:0]  OP_PASSA    = 5'b10000,
    parameter logic [4:0]  OP_PASSB    = 5'b01101
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] ir,
    input  logic        cond_ok,
    input  logic        moc,
    output logic [1:0]  MA,
    output logic [1:0]  MB,
    output logic [2:0]  MC,
    output logic        MD,
    output logic [4:0]  OP,
    output logic [1:0]  MF,
    output logic [1:0]  MJ,
    output logic        RFLd,
    output logic        IRLd,
    output logic        MARLd,
    output logic        MDRLd,
    output logic        FlagLd,
    output logic        MOV,
    output logic        RW,
    output logic        undef,
    output logic        mem_abort,
    output logic [4:0]  state
);

    typedef enum logic [4:0] {
        S_RESET = 5'd0,
        S_F0    = 5'd1,
        S_F1    = 5'd2,
        S_F2    = 5'd3,
        S_DEC   = 5'd4,
        S_DP    = 5'd5,
        S_MADDR = 5'd6,
        S_LDW   = 5'd7,
        S_LDWB  = 5'd8,
        S_STD   = 5'd9,
        S_STW   = 5'd10,
        S_BLNK  = 5'd11,
        S_BTGT  = 5'd12
    } state_e;

    localparam logic [3:0] TIMEOUT_CNT = 4'(MOC_TIMEOUT);
    localparam logic [4:0] OP_ADD      = 5'b00100;
    localparam logic [4:0] OP_SUB      = 5'b00010;

    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       in_wait;
    logic       timeout;
    logic       dec_known;
    logic       unused_ir;

    // Only the opcode class, P/U/L/S bits and immediate flag steer the sequencer.
    assign unused_ir = ^{ir[31:28], ir[19:0]};

    assign in_wait   = (state_q == S_F2) || (state_q == S_LDW) || (state_q == S_STW);
    // moc in the final allowed cycle still completes the transfer.
    assign timeout   = in_wait && !moc && (wait_q == TIMEOUT_CNT);
    assign dec_known = (ir[27:25] == 3'b000) || (ir[27:25] == 3'b001) ||
                       (ir[27:25] == 3'b010) || (ir[27:25] == 3'b101);

    // Next-state selection.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RESET: state_d = S_F0;
            S_F0:    state_d = S_F1;
            S_F1:    state_d = S_F2;
            S_F2: begin
                if (moc)          state_d = S_DEC;
                else if (timeout) state_d = S_F0;
            end
            S_DEC: begin
                if (!cond_ok) begin
                    state_d = S_F0;
                end else begin
                    case (ir[27:25])
                        3'b000, 3'b001: state_d = S_DP;
                        3'b010:         state_d = S_MADDR;
                        3'b101:         state_d = ir[24] ? S_BLNK : S_BTGT;
                        default:        state_d = S_F0;
                    endcase
                end
            end
            S_DP:    state_d = S_F0;
            S_MADDR: state_d = ir[20] ? S_LDW : S_STD;
            S_LDW: begin
                if (moc)          state_d = S_LDWB;
                else if (timeout) state_d = S_F0;
            end
            S_LDWB:  state_d = S_F0;
            S_STD:   state_d = S_STW;
            S_STW: begin
                if (moc || timeout) state_d = S_F0;
            end
            S_BLNK:  state_d = S_BTGT;
            S_BTGT:  state_d = S_F0;
            default: state_d = S_RESET;
        endcase
    end

    // Wait counter counts stalled cycles while parked in a memory state; zero elsewhere,
    // so every entry into a memory state starts from zero.
    always_comb begin
        wait_d = 4'd0;
        if (in_wait && !moc && !timeout) begin
            wait_d = wait_q + 4'd1;
        end
    end

    // State and wait counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_RESET;
            wait_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Control decode of the current state; anything not driven below stays 0.
    always_comb begin
        MA     = 2'd0;
        MB     = 2'd0;
        MC     = 3'd0;
        MD     = 1'b0;
        OP     = 5'd0;
        MF     = 2'd0;
        MJ     = 2'd0;
        RFLd   = 1'b0;
        IRLd   = 1'b0;
        MARLd  = 1'b0;
        MDRLd  = 1'b0;
        FlagLd = 1'b0;
        MOV    = 1'b0;
        RW     = 1'b0;
        undef  = 1'b0;
        case (state_q)
            S_F0: begin
                MA    = 2'd2;
                MD    = 1'b1;
                OP    = OP_PASSA;
                MARLd = 1'b1;
            end
            S_F1: begin
                MA   = 2'd2;
                MB   = 2'd3;
                MD   = 1'b1;
                OP   = OP_ADD;
                MC   = 3'd3;
                RFLd = 1'b1;
                MOV  = 1'b1;
                RW   = 1'b1;
            end
            S_F2: begin
                MOV  = 1'b1;
                RW   = 1'b1;
                IRLd = moc;
            end
            S_DEC: begin
                undef = cond_ok && !dec_known;
            end
            S_DP: begin
                MB     = ir[25] ? 2'd1 : 2'd0;
                FlagLd = ir[20];
                // Compare/test ops update flags only.
                RFLd   = (ir[24:23] != 2'b10);
            end
            S_MADDR: begin
                MB    = 2'd1;
                MD    = 1'b1;
                OP    = ir[23] ? OP_ADD : OP_SUB;
                MARLd = 1'b1;
            end
            S_LDW: begin
                MOV   = 1'b1;
                RW    = 1'b1;
                MDRLd = moc;
            end
            S_LDWB: begin
                MF   = 2'd1;
                RFLd = 1'b1;
            end
            S_STD: begin
                MJ    = 2'd2;
                MD    = 1'b1;
                OP    = OP_PASSB;
                MDRLd = 1'b1;
            end
            S_STW: begin
                MOV = 1'b1;
            end
            S_BLNK: begin
                MA   = 2'd2;
                MD   = 1'b1;
                OP   = OP_PASSA;
                MC   = 3'd2;
                RFLd = 1'b1;
            end
            S_BTGT: begin
                MA   = 2'd2;
                MB   = 2'd2;
                MD   = 1'b1;
                OP   = OP_ADD;
                MC   = 3'd3;
                RFLd = 1'b1;
            end
            default: ;
        endcase
    end

    assign mem_abort = timeout;
    assign state     = state_q;

endmodule
